// File: rtl/alu_wb_stage.sv
// ALU writeback stage: a 2-entry FIFO of {result, CNVZ} pairs plus the architectural CNVZ status register.
// Optional sticky-overflow bit with sticky_clr/sticky_v ports when ALU_WB_STICKY_V_EN is defined.
module alu_wb_stage #(
  parameter int bus = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [bus-1:0] in_s,
  input  logic [3:0]     in_cnvz,
  input  logic           in_setflags,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [bus-1:0] out_s,
  output logic [3:0]     out_cnvz,
  output logic [3:0]     flags,
  output logic [1:0]     count
`ifdef ALU_WB_STICKY_V_EN
  ,
  input  logic           sticky_clr,
  output logic           sticky_v
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready depends only on the registered count, never on out_ready.
  localparam int EW = bus + 4;

  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [3:0]    flags_q, flags_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_s     = out_valid ? head[EW-1:4] : '0;
  assign out_cnvz  = out_valid ? head[3:0] : 4'd0;
  assign flags     = flags_q;
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_s, in_cnvz};
      wr_ptr_d        = ~wr_ptr_q;
      if (in_setflags) flags_d = in_cnvz;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      flags_q  <= 4'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

`ifdef ALU_WB_STICKY_V_EN
  logic sticky_q, sticky_d;

  // A setting push wins over a clear in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = 1'b0;
    if (push && in_setflags && in_cnvz[1]) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_v = sticky_q;
`endif

endmodule
